// File: rtl/avalon_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : avalon_pkg
//  Description : Shared widths, constants and bus-bundle types for the
//                Avalon-MM responder and its read latency pipe.
//  Revision    : 1.0  initial release
// ============================================================================
package avalon_pkg;

    localparam int          WORD_W        = 32;
    localparam logic [31:0] BAD_READ_DATA = 32'hDEADBEEF;

    // Request side of the slave port as seen by the responder.
    typedef struct packed {
        logic [WORD_W-1:0] address;
        logic              read;
        logic              write;
        logic [WORD_W-1:0] writedata;
    } avalon_req_t;

    // Response side of the slave port.
    typedef struct packed {
        logic [WORD_W-1:0] readdata;
        logic              readdatavalid;
        logic              waitrequest;
    } avalon_rsp_t;

endpackage : avalon_pkg
`default_nettype wire

// File: rtl/read_latency_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : read_latency_pipe
//  Description : Fixed-depth shift register of {valid, data} stages that
//                delays accepted read data by READ_LATENCY cycles.
//                The final data stage only loads when a valid word arrives,
//                so out_data holds the last returned word between pulses.
//  Ports       : clk, rst_n      clock / async active-low reset
//                in_valid        read accepted this cycle
//                in_data         data sampled at acceptance
//                out_valid       one-cycle pulse READ_LATENCY cycles later
//                out_data        delayed data (held when out_valid=0)
//  Revision    : 1.0  initial release
// ============================================================================
module read_latency_pipe
    import avalon_pkg::*;
#(
    parameter int READ_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data
);

    logic [READ_LATENCY-1:0] r_valid;
    logic [WORD_W-1:0]       r_data [READ_LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid[0] <= 1'b0;
            r_data[0]  <= '0;
        end else begin
            r_valid[0] <= in_valid;
            if (in_valid) begin
                r_data[0] <= in_data;
            end
        end
    end

    for (genvar i = 1; i < READ_LATENCY; i++) begin : g_stage
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid[i] <= 1'b0;
                r_data[i]  <= '0;
            end else begin
                r_valid[i] <= r_valid[i-1];
                if (r_valid[i-1]) begin
                    r_data[i] <= r_data[i-1];
                end
            end
        end
    end

    assign out_valid = r_valid[READ_LATENCY-1];
    assign out_data  = r_data[READ_LATENCY-1];

endmodule : read_latency_pipe
`default_nettype wire

// File: rtl/avalon_sdram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : avalon_sdram_responder
//  Description : Avalon-MM slave backed by an on-chip word RAM. Each new
//                request is stalled WAIT_CYCLES cycles with waitrequest,
//                reads return READ_LATENCY cycles after acceptance.
//  Ports       : clk, rst_n            clock / async active-low reset
//                slave_address         byte address (bits [1:0] ignored)
//                slave_read/write      request strobes
//                slave_writedata       write data
//                slave_waitrequest     high = not accepted this cycle
//                slave_readdata        read data, qualified by readdatavalid
//                slave_readdatavalid   one pulse per accepted read
//                protocol_error        sticky: read and write together
//                rd_count / wr_count   accepted reads / writes since reset
//  Revision    : 1.0  initial release
// ============================================================================
module avalon_sdram_responder
    import avalon_pkg::*;
#(
    parameter int          DEPTH_WORDS  = 256,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          WAIT_CYCLES  = 1,
    parameter int          READ_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] slave_address,
    input  logic              slave_read,
    input  logic              slave_write,
    input  logic [WORD_W-1:0] slave_writedata,
    output logic              slave_waitrequest,
    output logic [WORD_W-1:0] slave_readdata,
    output logic              slave_readdatavalid,
    output logic              protocol_error,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count
);

    localparam int          c_IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  c_WAIT  = 4'(WAIT_CYCLES);
    localparam logic [31:0] c_DEPTH = 32'(DEPTH_WORDS);

    avalon_req_t        w_req;
    avalon_rsp_t        w_rsp;

    logic [3:0]         r_stall;
    logic               r_perr;
    logic [31:0]        r_rd_count;
    logic [31:0]        r_wr_count;
    logic [WORD_W-1:0]  r_ram [DEPTH_WORDS];

    logic [31:0]        w_offset;
    logic [31:0]        w_index;
    logic [c_IDX_W-1:0] w_ram_idx;
    logic               w_in_range;
    logic               w_one_req;
    logic               w_accept;
    logic               w_rd_accept;
    logic               w_wr_accept;
    logic [WORD_W-1:0]  w_rd_data;
    logic               w_pipe_valid;
    logic [WORD_W-1:0]  w_pipe_data;

    assign w_req = '{address:   slave_address,
                     read:      slave_read,
                     write:     slave_write,
                     writedata: slave_writedata};

    // The subtract wraps, so addresses below BASE_ADDR land far out of range.
    assign w_offset   = w_req.address - BASE_ADDR;
    assign w_index    = w_offset >> 2;
    assign w_in_range = (w_index < c_DEPTH);
    assign w_ram_idx  = w_index[c_IDX_W-1:0];

    assign w_one_req   = w_req.read ^ w_req.write;
    assign w_accept    = w_one_req && (r_stall == c_WAIT);
    assign w_rd_accept = w_accept && w_req.read;
    assign w_wr_accept = w_accept && w_req.write;

    // Any idle or illegal cycle restarts the stall, so a withdrawn request
    // must sit out the full wait again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= 4'd0;
        end else if (!w_one_req || w_accept) begin
            r_stall <= 4'd0;
        end else if (r_stall != c_WAIT) begin
            r_stall <= r_stall + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perr     <= 1'b0;
            r_rd_count <= 32'd0;
            r_wr_count <= 32'd0;
        end else begin
            if (w_req.read && w_req.write) begin
                r_perr <= 1'b1;
            end
            if (w_rd_accept) begin
                r_rd_count <= r_rd_count + 32'd1;
            end
            if (w_wr_accept) begin
                r_wr_count <= r_wr_count + 32'd1;
            end
        end
    end

    // Storage is deliberately not reset; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_wr_accept && w_in_range) begin
            r_ram[w_ram_idx] <= w_req.writedata;
        end
    end

    assign w_rd_data = w_in_range ? r_ram[w_ram_idx] : BAD_READ_DATA;

    read_latency_pipe #(
        .READ_LATENCY (READ_LATENCY)
    ) u_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (w_rd_accept),
        .in_data   (w_rd_data),
        .out_valid (w_pipe_valid),
        .out_data  (w_pipe_data)
    );

    assign w_rsp = '{readdata:      w_pipe_data,
                     readdatavalid: w_pipe_valid,
                     waitrequest:   !w_accept};

    assign slave_waitrequest   = w_rsp.waitrequest;
    assign slave_readdata      = w_rsp.readdata;
    assign slave_readdatavalid = w_rsp.readdatavalid;
    assign protocol_error      = r_perr;
    assign rd_count            = r_rd_count;
    assign wr_count            = r_wr_count;

endmodule : avalon_sdram_responder
`default_nettype wire
